// File: rtl/serial_rx_pkg.sv
// rtl/serial_rx_pkg.sv - types and helpers for the serial receiver
package serial_rx_pkg;

    `include "serial_defs.vh"

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        START   = ST_START,
        DATA    = ST_DATA,
        STOP    = ST_STOP,
        RECOVER = ST_RECOVER
    } rx_state_e;

    localparam int unsigned IDX_W = $clog2(DATA_BITS);

    // Bit counter width: must hold clks-1 without wrapping inside a bit.
    function automatic int unsigned cnt_width(input int unsigned clks);
        return (clks <= 2) ? 1 : $clog2(clks);
    endfunction

endpackage

// File: rtl/serial_defs.vh
// rtl/serial_defs.vh - frame constants and state encodings shared by serial_tx and serial_rx
`ifndef SERIAL_DEFS_VH
`define SERIAL_DEFS_VH

localparam int unsigned DATA_BITS  = 8;
localparam logic        LINE_IDLE  = 1'b1;

localparam logic [2:0]  ST_IDLE    = 3'd0;
localparam logic [2:0]  ST_START   = 3'd1;
localparam logic [2:0]  ST_DATA    = 3'd2;
localparam logic [2:0]  ST_STOP    = 3'd3;
localparam logic [2:0]  ST_RECOVER = 3'd4;

`endif

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous bit
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/serial_rx.sv
// rtl/serial_rx.sv - 8N1 serial receiver sampling mid-bit with break recovery
module serial_rx
    import serial_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 busy,
    output logic                 frame_err
);

    localparam int unsigned CNT_W = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic                 rx_s;

    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 busy_q, busy_d;

    sync_2ff #(
        .RESET_VAL (LINE_IDLE)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (rx_s)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_s != LINE_IDLE) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            // Re-check the start bit at its centre; a short low pulse is a glitch.
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = (rx_s == LINE_IDLE) ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s == LINE_IDLE) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = RECOVER;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // A held-low line must return high before another start bit counts.
            RECOVER: begin
                if (rx_s == LINE_IDLE) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign data_out  = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = busy_q;

    a_pulse_exclusive: assert property (@(posedge clk) disable iff (!rst)
        !(valid_q && ferr_q));

    a_idle_not_busy: assert property (@(posedge clk) disable iff (!rst)
        (state_q == IDLE) |-> !busy_q);

endmodule

// File: doc/serial_rx.md
SERIAL_RX -- requirements
Module: serial_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8: clock cycles per serial bit; legal range 4..65535.
REQ-002 SHALL have port clk  input  1: single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1: reset, synchronous and active-low.
REQ-004 SHALL have port rx  input  1: asynchronous serial line, idle high.
REQ-005 SHALL have port data_out  output  8: last correctly framed byte received.
REQ-006 SHALL have port valid  output  1: one-cycle pulse; data_out updated this cycle.
REQ-007 SHALL have port busy  output  1: high while a frame is being received.
REQ-008 SHALL have port frame_err  output  1: one-cycle pulse when the stop bit is sampled low.

Function
REQ-009 SHALL accept the frame format emitted by serial_tx: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each CLKS_PER_BIT cycles long.
REQ-010 SHALL pass rx through a 2-flop synchronizer before any use; the synchronizer flops reset to 1. The synchronized signal is rx_s.
REQ-011 SHALL implement states IDLE, START, DATA, STOP, RECOVER, with bit counter cnt and bit index idx.
REQ-012 IDLE: when rx_s==0, go to START with cnt=0.
REQ-013 START: count to H-1, where H=CLKS_PER_BIT/2 (integer division). Then go to DATA if rx_s==0, with cnt=0 and idx=0. Otherwise return to IDLE as a glitch, with no pulse on any output.
REQ-014 DATA: at cnt==CLKS_PER_BIT-1, shift rx_s into bit idx of the shift register and reset cnt=0. Go to STOP if idx==7; otherwise increment idx.
REQ-015 STOP: at cnt==CLKS_PER_BIT-1, act on rx_s. If rx_s==1: load data_out from the shift register, pulse valid, go to IDLE. If rx_s==0: pulse frame_err, leave data_out unchanged, go to RECOVER.
REQ-016 RECOVER: stay until rx_s==1, then go to IDLE. A held-low line (break) SHALL NOT start a new frame.
REQ-017 Latency: valid (or frame_err) SHALL be high in the cycle after the edge 2+H+9*CLKS_PER_BIT cycles after the first clock edge that samples rx low. For CLKS_PER_BIT=8 this is edge +78.
REQ-018 valid and frame_err SHALL never be high together, and each SHALL be high for exactly one cycle per frame.
REQ-019 busy SHALL be 1 in START, DATA, STOP and RECOVER, and 0 in IDLE. busy SHALL be registered with the state (same-cycle state decode).
REQ-020 A falling edge arriving on the cycle after valid SHALL start the next frame; back-to-back frames with no idle gap SHALL be received without loss.
REQ-021 rx activity during DATA or STOP SHALL only be sampled at the counter terminal count; mid-bit glitches SHALL NOT be sampled.
REQ-022 cnt SHALL be wide enough for CLKS_PER_BIT-1 (clog2) and SHALL NOT wrap within a bit.

Reset
REQ-023 With rst==0 at a rising edge, the block SHALL set: state=IDLE, cnt=0, idx=0, shift register=0, data_out=8'h00, valid=0, frame_err=0, busy=0, synchronizer flops=1.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no valid/frame_err pulse. The first edge after release SHALL be in IDLE.

Structure
REQ-025 Shared include serial_defs.vh SHALL hold DATA_BITS=8, the line idle level, and the state encodings (IDLE=0, START=1, DATA=2, STOP=3, RECOVER=4), for common use by serial_tx and serial_rx.
REQ-026 The synchronizer SHALL be a separate sub-module sync_2ff (1-bit, reset value parameter), instantiated once.
REQ-027 All outputs SHALL be driven directly from flops; no combinational path from rx to any output.

Verification (CLKS_PER_BIT=8, 10 ns clock)
REQ-028 Loopback serial_tx->serial_rx, send 8'hA5 then 8'h3C -> data_out=A5 then 3C, one valid pulse each, frame_err never high.
REQ-029 Drive rx=0 for 3 cycles, then 1 -> glitch rejected at START; busy high briefly; no valid; back in IDLE.
REQ-030 Hand-built frame 8'h5A with stop bit 0, line held low 40 cycles -> frame_err pulse at edge +78; data_out keeps the previous value; no new frame until rx is high, then IDLE.
REQ-031 Back-to-back frames 8'hFF, 8'h00, 8'h81 with no gap -> three valid pulses exactly 80 cycles apart, correct bytes.
REQ-032 Assert rst (low) during DATA bit 4 of 8'hC3 -> all outputs at reset values next cycle; no pulse; the following clean frame 8'h12 is received correctly.
REQ-033 Assertions SHALL check for the whole run: valid&&frame_err never true; busy==0 whenever state==IDLE.
